// File: rtl/game_pkg.sv
// Shared types for the memory-game controller and datapath.
// State codes, command-vector layout and the per-state command decode.
package game_pkg;

  localparam int STATE_W = 3;
  localparam int CMD_W   = 7;

  localparam int CMD_R1  = 6;
  localparam int CMD_R2  = 5;
  localparam int CMD_E1  = 4;
  localparam int CMD_E2  = 3;
  localparam int CMD_E3  = 2;
  localparam int CMD_E4  = 1;
  localparam int CMD_SEL = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_PLAY_FPGA  = 3'd2,
    ST_PLAY_USER  = 3'd3,
    ST_CHECK      = 3'd4,
    ST_NEXT_ROUND = 3'd5,
    ST_EVAL       = 3'd6,
    ST_RESULT     = 3'd7
  } state_t;

  typedef logic [CMD_W-1:0] cmd_t;

  function automatic cmd_t cmd_decode(state_t s);
    cmd_t c;
    c = '0;
    unique case (s)
      ST_INIT: begin
        c[CMD_R1]  = 1'b1;
        c[CMD_R2]  = 1'b1;
        c[CMD_SEL] = 1'b1;
      end
      ST_SETUP: begin
        c[CMD_E1]  = 1'b1;
        c[CMD_SEL] = 1'b1;
      end
      ST_PLAY_FPGA: begin
        c[CMD_E3]  = 1'b1;
        c[CMD_SEL] = 1'b1;
      end
      ST_PLAY_USER: begin
        c[CMD_E2]  = 1'b1;
        c[CMD_SEL] = 1'b1;
      end
      ST_CHECK: begin
        c[CMD_SEL] = 1'b1;
      end
      ST_NEXT_ROUND: begin
        c[CMD_E4]  = 1'b1;
        c[CMD_R2]  = 1'b1;
        c[CMD_SEL] = 1'b1;
      end
      ST_EVAL: begin
        c[CMD_SEL] = 1'b1;
      end
      ST_RESULT: begin
        c = '0;
      end
      default: begin
        c[CMD_R1]  = 1'b1;
        c[CMD_R2]  = 1'b1;
        c[CMD_SEL] = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/game_controller_edge_detect.sv
// Rising-edge detector for a synchronized key level.
// One-cycle pulse on each 0->1 transition of d.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_controller.sv
// Moore sequencer for the memory-game datapath.
// Commands are registered from the next state, so they track state_o exactly.
module game_controller #(
  parameter int CHECK_CYCLES = 2,
  parameter int STATE_W      = 3
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               enter,
  input  logic               end_fpga,
  input  logic               end_user,
  input  logic               end_time,
  input  logic               win,
  input  logic               match,
  output logic               r1,
  output logic               r2,
  output logic               e1,
  output logic               e2,
  output logic               e3,
  output logic               e4,
  output logic               sel,
  output logic [STATE_W-1:0] state_o
);

  import game_pkg::*;

  localparam logic [3:0] CHK_LAST = 4'(CHECK_CYCLES - 1);

  state_t     state;
  state_t     state_n;
  cmd_t       cmd;
  logic [3:0] chk_cnt;
  logic       enter_rise;

  edge_detect u_enter_edge (
    .clk   (clock_50),
    .reset (reset),
    .d     (enter),
    .rise  (enter_rise)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_INIT: begin
        state_n = ST_SETUP;
      end
      ST_SETUP: begin
        if (enter_rise) state_n = ST_PLAY_FPGA;
      end
      ST_PLAY_FPGA: begin
        if (end_fpga) state_n = ST_PLAY_USER;
      end
      ST_PLAY_USER: begin
        // A timeout beats a simultaneous completion: the round is lost.
        if (end_time) begin
          state_n = ST_RESULT;
        end else if (end_user) begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_cnt >= CHK_LAST) begin
          state_n = match ? ST_NEXT_ROUND : ST_RESULT;
        end
      end
      ST_NEXT_ROUND: begin
        state_n = ST_EVAL;
      end
      ST_EVAL: begin
        state_n = win ? ST_RESULT : ST_PLAY_FPGA;
      end
      ST_RESULT: begin
        if (enter_rise) state_n = ST_INIT;
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state   <= ST_INIT;
      chk_cnt <= 4'd0;
      cmd     <= cmd_decode(ST_INIT);
    end else begin
      state <= state_n;
      cmd   <= cmd_decode(state_n);
      if (state_n == ST_CHECK && state != ST_CHECK) begin
        chk_cnt <= 4'd0;
      end else if (state == ST_CHECK && chk_cnt != 4'hF) begin
        chk_cnt <= chk_cnt + 4'd1;
      end
    end
  end

  assign r1      = cmd[CMD_R1];
  assign r2      = cmd[CMD_R2];
  assign e1      = cmd[CMD_E1];
  assign e2      = cmd[CMD_E2];
  assign e3      = cmd[CMD_E3];
  assign e4      = cmd[CMD_E4];
  assign sel     = cmd[CMD_SEL];
  assign state_o = STATE_W'(state);

endmodule
